// File: rtl/piso_shift_register.sv
// -----------------------------------------------------------------------------
// piso_shift_register
//
// Parallel-in serial-out transmitter. A WIDTH-bit word is taken in through a
// valid/ready handshake and sent out one bit per shift_en strobe on `so`.
// Words can stream back to back with no gap bits between them.
//
// Handshake (load side):
//   A word transfers on a rising clk edge where load_valid && load_ready.
//   The producer holds pi and load_valid until that edge. load_ready is not
//   a promise for later cycles. When the last bit of a word is consumed
//   (cnt==0 && shift_en), load_ready goes high combinationally from
//   shift_en so that the next word can be accepted on the same edge.
//
// Ports:
//   clk         rising-edge clock
//   clear_n     asynchronous active-low reset
//   pi          parallel word to transmit
//   load_valid  pi holds a word to send
//   load_ready  block can accept a word this cycle
//   shift_en    bit strobe; the current so bit is consumed on this edge
//   so          serial data out (0 when idle)
//   so_valid    so carries a frame bit
//   so_last     current so bit is the final bit of its word
//   fsm_state   current FSM state (0 = IDLE, 1 = SHIFT), for observation
// -----------------------------------------------------------------------------
module piso_shift_register #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] pi,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             fsm_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_START = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    logic last_bit;
    logic last_consumed;
    logic accept;
    logic out_bit;

    assign last_bit      = (state == SHIFT) && (cnt == '0);
    assign last_consumed = last_bit && shift_en;

    // Gated by clear_n so load_ready stays low while the block is held in reset.
    assign load_ready = clear_n && ((state == IDLE) || last_consumed);
    assign accept     = load_valid && load_ready;

    assign out_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    assign so        = (state == SHIFT) && out_bit;
    assign so_valid  = (state == SHIFT);
    assign so_last   = last_bit;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg  <= pi;
                        cnt   <= CNT_START;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (cnt == '0) begin
                            // Last bit leaves on this edge; reload at once
                            // if a word is waiting so the stream has no gap.
                            if (accept) begin
                                sreg  <= pi;
                                cnt   <= CNT_START;
                                state <= SHIFT;
                            end else begin
                                sreg  <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            // Move the next bit toward the output end, zero-fill.
                            if (MSB_FIRST) begin
                                sreg <= {sreg[WIDTH-2:0], 1'b0};
                            end else begin
                                sreg <= {1'b0, sreg[WIDTH-1:1]};
                            end
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_register.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_register
//
// Drives one MSB-first and one LSB-first instance with the same stimulus and
// checks the selected one against a bit-queue reference: each accepted word
// pushes its bits in send order, each consumed bit pops one.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_piso_shift_register;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         clear_n = 1'b0;
    logic [W-1:0] pi = '0;
    logic         load_valid = 1'b0;
    logic         shift_en = 1'b0;

    always #5 clk = ~clk;

    logic load_ready_h, so_h, so_valid_h, so_last_h, fsm_state_h;
    logic load_ready_l, so_l, so_valid_l, so_last_l, fsm_state_l;

    piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .clear_n    (clear_n),
        .pi         (pi),
        .load_valid (load_valid),
        .load_ready (load_ready_h),
        .shift_en   (shift_en),
        .so         (so_h),
        .so_valid   (so_valid_h),
        .so_last    (so_last_h),
        .fsm_state  (fsm_state_h)
    );

    piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .clear_n    (clear_n),
        .pi         (pi),
        .load_valid (load_valid),
        .load_ready (load_ready_l),
        .shift_en   (shift_en),
        .so         (so_l),
        .so_valid   (so_valid_l),
        .so_last    (so_last_l),
        .fsm_state  (fsm_state_l)
    );

    // Instance under check: 0 = MSB-first, 1 = LSB-first.
    logic lsb_mode = 1'b0;
    logic so_m, so_valid_m, so_last_m, load_ready_m, fsm_state_m;
    assign so_m         = lsb_mode ? so_l         : so_h;
    assign so_valid_m   = lsb_mode ? so_valid_l   : so_valid_h;
    assign so_last_m    = lsb_mode ? so_last_l    : so_last_h;
    assign load_ready_m = lsb_mode ? load_ready_l : load_ready_h;
    assign fsm_state_m  = lsb_mode ? fsm_state_l  : fsm_state_h;

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    logic [0:0] last_q[$];
    int checks = 0;
    int errors = 0;
    logic cur_se;
    logic cur_acc;
    logic [W-1:0] cur_pi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] p);
        for (int i = 0; i < W; i++) begin
            int idx;
            idx = lsb_mode ? i : (W - 1 - i);
            exp_q.push_back(p[idx]);
            last_q.push_back(1'(i == W - 1));
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        last_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge: drive, settle, compare against model.
    task automatic drive_sample(input logic lv, input logic [W-1:0] p, input logic se);
        logic e_v, e_so, e_l, e_rdy;
        load_valid = lv;
        pi         = p;
        shift_en   = se;
        #1;
        e_v   = (exp_q.size() != 0);
        e_so  = e_v ? exp_q[0] : 1'b0;
        e_l   = e_v ? last_q[0] : 1'b0;
        e_rdy = !e_v || (exp_q.size() == 1 && se);
        check("so",         {31'd0, so_m},         {31'd0, e_so});
        check("so_valid",   {31'd0, so_valid_m},   {31'd0, e_v});
        check("so_last",    {31'd0, so_last_m},    {31'd0, e_l});
        check("load_ready", {31'd0, load_ready_m}, {31'd0, e_rdy});
        cur_se  = se;
        cur_acc = lv && e_rdy;
        cur_pi  = p;
    endtask

    task automatic advance();
        @(posedge clk);
        if (cur_se && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            void'(last_q.pop_front());
        end
        if (cur_acc) push_word(cur_pi);
        #1;
    endtask

    task automatic cycle(input logic lv, input logic [W-1:0] p, input logic se);
        drive_sample(lv, p, se);
        advance();
    endtask

    task automatic apply_reset();
        clear_n    = 1'b0;
        load_valid = 1'b0;
        shift_en   = 1'b0;
        #2;
        flush_model();
        check("rst_so",         {31'd0, so_m},         32'd0);
        check("rst_so_valid",   {31'd0, so_valid_m},   32'd0);
        check("rst_so_last",    {31'd0, so_last_m},    32'd0);
        check("rst_load_ready", {31'd0, load_ready_m}, 32'd0);
        check("rst_state",      {31'd0, fsm_state_m},  32'd0);
        @(posedge clk);
        #1;
        clear_n = 1'b1;
        #1;
        check("rst_rel_ready", {31'd0, load_ready_m}, 32'd1);
        check("rst_valid_known", {31'd0, $isunknown(so_valid_m)}, 32'd0);
    endtask

    // ---------------- table for the basic frame ----------------
    typedef struct {
        logic         lv;
        logic [W-1:0] p;
        logic         se;
        logic         e_so;
        logic         e_v;
        logic         e_l;
        logic         e_rdy;
    } vec_t;

    vec_t tab[10];

    initial begin
        // Load A5 MSB-first with shift_en high; bits 1,0,1,0,0,1,0,1 then idle.
        tab[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tab[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // X on load_valid while held in reset must not leave X behind.
        load_valid = 1'bx;
        #3;
        apply_reset();

        // 1: single A5 frame, table-driven
        for (int i = 0; i < 10; i++) begin
            drive_sample(tab[i].lv, tab[i].p, tab[i].se);
            check("tab_so",    {31'd0, so_m},         {31'd0, tab[i].e_so});
            check("tab_valid", {31'd0, so_valid_m},   {31'd0, tab[i].e_v});
            check("tab_last",  {31'd0, so_last_m},    {31'd0, tab[i].e_l});
            check("tab_ready", {31'd0, load_ready_m}, {31'd0, tab[i].e_rdy});
            advance();
        end

        // 2: back-to-back A5 then 3C with load_valid held
        cycle(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1);

        // 3: gappy shift_en on F0
        begin
            logic [10:0] pat;
            pat = 11'b11111011001;  // applied LSB first: 1,0,0,1,1,0,1,1,1,1,1
            cycle(1'b1, 8'hF0, 1'b1);
            for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, pat[i]);
            cycle(1'b0, 8'h00, 1'b1);
        end

        // 5: asynchronous reset mid-frame, then clean frame 81
        cycle(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        load_valid = 1'b0;
        #2;
        clear_n = 1'b0;
        #1;
        flush_model();
        check("async_so",       {31'd0, so_m},         32'd0);
        check("async_so_valid", {31'd0, so_valid_m},   32'd0);
        check("async_so_last",  {31'd0, so_last_m},    32'd0);
        check("async_ready",    {31'd0, load_ready_m}, 32'd0);
        #2;
        clear_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h81, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1);

        // 6: load attempt mid-word is ignored until the last-bit edge
        cycle(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1);

        // random streaming, MSB-first
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1);

        // 4: LSB-first instance
        lsb_mode = 1'b1;
        apply_reset();
        cycle(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h0F, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
Parallel-in serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock on a serial line. It is the transmit-side counterpart of the team's serial-in parallel-out shift register, and feeds the serial links that register receives. A per-cycle shift strobe paces the output. Back-to-back words stream with no gap bits.

Parameters:
WIDTH, 8, word width in bits (legal: 2 or more).
MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.

Ports:
clk  input  1  rising-edge clock.
clear_n  input  1  asynchronous active-low reset.
pi  input  WIDTH  parallel word to transmit.
load_valid  input  1  pi holds a word to send.
load_ready  output  1  block can accept a word this cycle.
shift_en  input  1  bit strobe: current so bit is consumed on this edge.
so  output  1  serial data out.
so_valid  output  1  so carries a frame bit.
so_last  output  1  current so bit is the final bit of the word.

Behaviour:
- Reset:
  - Asynchronous, active-low on clear_n: both the reset and clock/reset sensitivity are fixed.
  - While clear_n=0: state=IDLE, shift register=0, bit counter=0, so=0, so_valid=0, so_last=0, load_ready=0.
  - load_ready rises combinationally once clear_n=1 (state is IDLE).
- Storage:
  - Shift register sreg[WIDTH-1:0].
  - Down-counter cnt of width clog2(WIDTH).
  - 2-state FSM: IDLE, SHIFT.
- Outputs (all functions of registered state only, except load_ready):
  - so = MSB_FIRST ? sreg[WIDTH-1] : sreg[0] in SHIFT; 0 in IDLE.
  - so_valid = (state==SHIFT).
  - so_last = (state==SHIFT && cnt==0).
  - load_ready = (state==IDLE) || (state==SHIFT && cnt==0 && shift_en). This is combinational from shift_en.
- Accept:
  - A word is accepted on a rising edge with load_valid && load_ready.
  - On accept: sreg<=pi, cnt<=WIDTH-1, state<=SHIFT.
  - The first bit appears on so the cycle after accept (latency 1).
- SHIFT with shift_en=0: sreg, cnt and so hold; no bit is consumed.
- SHIFT with shift_en=1 and cnt>0:
  - sreg shifts toward the output end: MSB_FIRST=1 shifts left, 0 shifts right.
  - Vacated bit is filled with 0.
  - cnt decrements.
- SHIFT with shift_en=1 and cnt==0 (last bit consumed):
  - If load_valid=1: the new word is accepted on the same edge. State stays SHIFT with no idle cycle, so the serial stream is continuous.
  - Otherwise: state<=IDLE, so drops to 0.
- Load attempts while load_ready=0 are ignored. pi is not sampled, and the word in flight is not disturbed.
- The word takes exactly WIDTH shift_en-high cycles. With shift_en tied high, a word occupies WIDTH consecutive cycles.
- pi is sampled only at accept. Changes to pi afterwards have no effect.
- Reset mid-frame aborts the word immediately: all outputs go to reset values and the partial word is discarded.
- X on load_valid during IDLE must not corrupt state. The bench checks that no X appears on so_valid after reset.

Test Plan:
1. Reset, then load 8'hA5 (MSB_FIRST=1), shift_en=1 -> so = 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; so_valid high for 8 cycles; so_last high only on cycle 8; so=0 and so_valid=0 on cycle 9.
2. Back-to-back: 8'hA5 then 8'h3C presented with load_valid held -> 16 contiguous bits 10100101 00111100; load_ready pulses only on bit 8; so_valid never drops between words.
3. shift_en pattern 1,0,0,1,1,0,1,1,1,1,1 on word 8'hF0 -> each bit held on so across shift_en=0 cycles; sequence 1,1,1,1,0,0,0,0; completes after the 8th shift_en=1.
4. MSB_FIRST=0, load 8'hA5 -> so = 1,0,1,0,0,1,0,1 in bit-0-first order (a5 LSB first); so_last on the 8th bit.
5. Load 8'hFF, pulse clear_n low for 3 ns asynchronously (not on a clock edge) after the 3rd bit -> so, so_valid, so_last go to 0 immediately. After release, load 8'h81 -> 1,0,0,0,0,0,0,1 with no residue of 8'hFF.
6. Load 8'h55, then mid-word assert load_valid with pi=8'hFF -> load_ready=0, word 8'h55 completes intact; 8'hFF accepted only on the last-bit edge and sent next.
